// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial transmitter.
package serializer_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int unsigned MOD_ILL_A = 1;
  localparam int unsigned MOD_ILL_B = 2;

  // Bit count for a data_mod value; 0 flags a request that must be dropped.
  function automatic int unsigned mod_to_len(input int unsigned mod, input int unsigned width);
    if (mod == 0) return width;
    if (mod == MOD_ILL_A || mod == MOD_ILL_B) return 0;
    return mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// MSB-first parallel-to-serial converter with per-bit valid and registered busy.
module serializer
  import serializer_pkg::*;
#(
  parameter  int unsigned DATA_BUS_WIDTH = 16,
  localparam int unsigned MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]      data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam int unsigned W  = DATA_BUS_WIDTH;
  localparam int unsigned CW = MOD_WIDTH + 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sh_q, sh_d;
  logic            sdo_d, sval_d, busy_d;
  logic [CW-1:0]   len;
  logic            acc;

  assign len = CW'(mod_to_len(32'(data_mod_i), W));
  // busy_o is only low when idle or on the last bit, so accepts never cut a word short.
  assign acc = data_val_i && !busy_o && (len != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sdo_d   = 1'b0;
    sval_d  = 1'b0;
    busy_d  = 1'b0;
    if (acc) begin
      state_d = SHIFT;
      sdo_d   = data_i[W-1];
      sh_d    = {data_i[W-2:0], 1'b0};
      cnt_d   = len;
      sval_d  = 1'b1;
      busy_d  = (len > CW'(1));
    end else if (state_q == SHIFT && cnt_q > CW'(1)) begin
      sdo_d   = sh_q[W-1];
      sh_d    = {sh_q[W-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
      sval_d  = 1'b1;
      busy_d  = (cnt_q > CW'(2));
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sh_q           <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sh_q           <= sh_d;
      ser_data_o     <= sdo_d;
      ser_data_val_o <= sval_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench: accepted words push their bits to a queue, every cycle pops and compares.
module tb_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         srst;
  logic [W-1:0] data;
  logic [3:0]   mod;
  logic         val;
  logic         ser_data, ser_val, busy;

  int n_chk = 0;
  int n_fail = 0;

  bit      exp_q[$];
  logic    mbusy = 1'b0;
  logic [W-1:0] rx = '0;
  int      nval = 0;

  serializer #(.DATA_BUS_WIDTH(W)) dut (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(mod), .data_val_i(val),
    .ser_data_o(ser_data), .ser_data_val_o(ser_val), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [3:0] m);
    if (m == 0) return W;
    if (m == 1 || m == 2) return 0;
    return int'(m);
  endfunction

  // Sample the cycle that just began, then drive inputs for the next edge.
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, input logic [3:0] m);
    bit b;
    int n;
    @(posedge clk); #1;
    if (exp_q.size() > 0) begin
      mbusy = (exp_q.size() > 1);
      b = exp_q.pop_front();
      chk("val", 32'(ser_val), 32'd1);
      chk("bit", 32'(ser_data), 32'(b));
    end else begin
      mbusy = 1'b0;
      chk("val_idle", 32'(ser_val), 32'd0);
      chk("bit_idle", 32'(ser_data), 32'd0);
    end
    chk("busy", 32'(busy), 32'(mbusy));
    if (ser_val) begin
      rx = {rx[W-2:0], ser_data};
      nval++;
    end
    srst = r; val = v; data = d; mod = m;
    n = len_of(m);
    if (r) begin
      exp_q.delete();
    end else if (v && !mbusy && n != 0) begin
      for (int i = 0; i < n; i++) exp_q.push_back(d[W-1-i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'(i * 16'h1357), 4'(i));
  endtask

  initial begin
    srst = 1'b1; val = 1'b0; data = '0; mod = '0;
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b0, 1'b0, '0, '0);
    idle(10);

    // full word plus loopback reassembly
    nval = 0;
    cyc(1'b0, 1'b1, 16'hA5C3, 4'd0);
    idle(16);
    chk("loop_word", 32'(rx), 32'h0000A5C3);
    chk("loop_cnt", nval, 16);
    idle(3);

    // partial and illegal lengths
    nval = 0;
    cyc(1'b0, 1'b1, 16'hF000, 4'd5);
    idle(7);
    chk("part_cnt", nval, 5);
    chk("part_bits", 32'(rx[4:0]), 32'h1E);
    nval = 0;
    cyc(1'b0, 1'b1, 16'hFFFF, 4'd1);
    cyc(1'b0, 1'b1, 16'hFFFF, 4'd2);
    idle(4);
    chk("illegal_cnt", nval, 0);

    // back-to-back words on the last-bit cycle
    nval = 0;
    cyc(1'b0, 1'b1, 16'hFFFF, 4'd0);
    idle(15);
    cyc(1'b0, 1'b1, 16'h0000, 4'd0);
    idle(16);
    chk("b2b_cnt", nval, 32);
    idle(2);

    // mid-word pulse is ignored
    cyc(1'b0, 1'b1, 16'h8001, 4'd0);
    idle(5);
    cyc(1'b0, 1'b1, 16'h7FFE, 4'd0);
    idle(14);
    idle(2);

    // reset on the 6th bit, then a fresh word
    cyc(1'b0, 1'b1, 16'h1234, 4'd0);
    idle(5);
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 16'hC00F, 4'd0);
    idle(18);

    // random traffic
    for (int i = 0; i < 2000; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
          16'($urandom), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b0, 1'b0, '0, '0);
    chk("drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
